// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared constants and helpers for the pipelined carry-select adder.
//   OP_ADD / OP_SUB   : values of the in_sub operation select
//   calc_nseg()       : number of SEG-bit segments in a WIDTH-bit operand
//   sat_max_pos()     : 0x7F..F pattern for a given width (LSB-aligned)
//   sat_min_neg()     : 0x80..0 pattern for a given width (LSB-aligned)
// The saturation helpers return a wide vector; callers slice off WIDTH bits.
// ---------------------------------------------------------------------------
package csa_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int SAT_MAX_W = 256;
   localparam logic [SAT_MAX_W-1:0] SAT_ONE = {{(SAT_MAX_W-1){1'b0}}, 1'b1};

   function automatic int calc_nseg(input int width, input int seg);
      return width / seg;
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_max_pos(input int width);
      return (SAT_ONE << (width - 1)) - SAT_ONE;
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_min_neg(input int width);
      return SAT_ONE << (width - 1);
   endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder_if
// Operand/result handshake bundle for csa_pipe_adder.
//   in_valid / in_ready   : operand beat handshake (source -> adder)
//   in_a, in_b            : operands, WIDTH bits
//   in_cin                : carry/borrow chain input
//   in_sub                : 0 = add, 1 = subtract
//   out_valid / out_ready : result handshake (adder -> consumer)
//   out_sum               : result, WIDTH bits
//   out_cout              : carry out of the MSB (no-borrow in subtract)
//   out_ovf               : signed two's-complement overflow
// Modports: master = operand source / result consumer side, slave = adder.
// ---------------------------------------------------------------------------
interface csa_pipe_adder_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid,
      input  in_ready,
      output in_a,
      output in_b,
      output in_cin,
      output in_sub,
      input  out_valid,
      output out_ready,
      input  out_sum,
      input  out_cout,
      input  out_ovf
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_a,
      input  in_b,
      input  in_cin,
      input  in_sub,
      output out_valid,
      input  out_ready,
      output out_sum,
      output out_cout,
      output out_ovf
   );

endinterface

// File: rtl/csa_segment.sv
// ---------------------------------------------------------------------------
// csa_segment
// One SEG-bit slice of the carry-select adder. Computes both candidate
// results so the select chain can pick one once the real carry-in is known.
//   seg_a, seg_b : segment operand bits (seg_b already conditionally inverted)
//   sum0, c0     : sum and carry-out assuming carry-in 0
//   sum1, c1     : sum and carry-out assuming carry-in 1
//   msb_c0/1     : carry into the segment MSB for carry-in 0 / 1
// ---------------------------------------------------------------------------
module csa_segment #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] seg_a,
   input  logic [SEG-1:0] seg_b,
   output logic [SEG-1:0] sum0,
   output logic [SEG-1:0] sum1,
   output logic           c0,
   output logic           c1,
   output logic           msb_c0,
   output logic           msb_c1
);

   always_comb begin
      {c0, sum0} = {1'b0, seg_a} + {1'b0, seg_b};
      {c1, sum1} = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, 1'b1};
      // sum_msb = a ^ b ^ carry_in_msb, so the carry into the MSB falls out
      // of the result without a second adder.
      msb_c0 = sum0[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];
      msb_c1 = sum1[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];
   end

endmodule

// File: rtl/csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow
// control. Stage 1 registers both candidate results of every SEG-bit
// segment; stage 2 resolves the carry-select chain into the output register.
// Latency 2 cycles, throughput 1 beat/cycle, capacity 2 beats.
//   clk            : rising-edge clock
//   rst_n          : synchronous active-low reset
//   bus (slave)    : operand and result handshake, see csa_pipe_adder_if
// Parameters: WIDTH (multiple of SEG), SEG (segment width).
// Build option: CSA_SATURATION_EN - when defined, an overflowing result
// saturates to 0x7F..F / 0x80..0; otherwise the sum wraps modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module csa_pipe_adder
   import csa_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   csa_pipe_adder_if.slave    bus
);

   localparam int NSEG = calc_nseg(WIDTH, SEG);

   if (SEG < 1 || (WIDTH % SEG) != 0 || NSEG < 1) begin : g_bad_cfg
      $error("csa_pipe_adder: WIDTH must be a non-zero multiple of SEG");
   end

   // ---------------- stage 1: operand conditioning and segments ----------
   logic                      sub_op;
   logic [WIDTH-1:0]          b_eff;
   logic                      c_eff;
   logic [NSEG-1:0][SEG-1:0]  seg_sum0;
   logic [NSEG-1:0][SEG-1:0]  seg_sum1;
   logic [NSEG-1:0]           seg_c0;
   logic [NSEG-1:0]           seg_c1;
   logic [NSEG-1:0]           seg_mc0;
   logic [NSEG-1:0]           seg_mc1;
   logic                      unused_mc;

   assign sub_op = (bus.in_sub == OP_SUB);
   assign b_eff  = bus.in_b ^ {WIDTH{sub_op}};
   assign c_eff  = bus.in_cin ^ sub_op;

   for (genvar i = 0; i < NSEG; i++) begin : g_seg
      csa_segment #(
         .SEG (SEG)
      ) u_seg (
         .seg_a  (bus.in_a[i*SEG +: SEG]),
         .seg_b  (b_eff[i*SEG +: SEG]),
         .sum0   (seg_sum0[i]),
         .sum1   (seg_sum1[i]),
         .c0     (seg_c0[i]),
         .c1     (seg_c1[i]),
         .msb_c0 (seg_mc0[i]),
         .msb_c1 (seg_mc1[i])
      );
   end

   // Only the top segment's MSB carry-in matters for overflow.
   assign unused_mc = ^{seg_mc0, seg_mc1};

   // ---------------- pipeline registers -----------------------------------
   logic                      s1_valid_q, s1_valid_d;
   logic [NSEG-1:0][SEG-1:0]  s1_sum0_q,  s1_sum0_d;
   logic [NSEG-1:0][SEG-1:0]  s1_sum1_q,  s1_sum1_d;
   logic [NSEG-1:0]           s1_c0_q,    s1_c0_d;
   logic [NSEG-1:0]           s1_c1_q,    s1_c1_d;
   logic                      s1_mc0_q,   s1_mc0_d;
   logic                      s1_mc1_q,   s1_mc1_d;
   logic                      s1_ceff_q,  s1_ceff_d;

   logic                      out_valid_q, out_valid_d;
   logic [WIDTH-1:0]          out_sum_q,   out_sum_d;
   logic                      out_cout_q,  out_cout_d;
   logic                      out_ovf_q,   out_ovf_d;

   // ---------------- stage 2: carry-select resolution ---------------------
   logic [NSEG:0]             carry;
   logic [WIDTH-1:0]          sel_sum;
   logic                      sel_mc;
   logic                      sel_cout;
   logic                      sel_ovf;
   logic [WIDTH-1:0]          res_sum;

   always_comb begin : p_select
      carry    = '0;
      sel_sum  = '0;
      carry[0] = s1_ceff_q;
      for (int i = 0; i < NSEG; i++) begin
         carry[i+1]             = carry[i] ? s1_c1_q[i]   : s1_c0_q[i];
         sel_sum[i*SEG +: SEG]  = carry[i] ? s1_sum1_q[i] : s1_sum0_q[i];
      end
      sel_mc   = carry[NSEG-1] ? s1_mc1_q : s1_mc0_q;
      sel_cout = carry[NSEG];
      sel_ovf  = sel_mc ^ sel_cout;
   end

`ifdef CSA_SATURATION_EN
   localparam logic [SAT_MAX_W-1:0] SAT_POS_W = sat_max_pos(WIDTH);
   localparam logic [SAT_MAX_W-1:0] SAT_NEG_W = sat_min_neg(WIDTH);
   localparam logic [WIDTH-1:0]     SAT_POS   = SAT_POS_W[WIDTH-1:0];
   localparam logic [WIDTH-1:0]     SAT_NEG   = SAT_NEG_W[WIDTH-1:0];

   // On overflow both operands share a sign, and that sign equals the carry
   // out of the MSB, so cout picks the saturation rail directly.
   assign res_sum = sel_ovf ? (sel_cout ? SAT_NEG : SAT_POS) : sel_sum;
`else
   assign res_sum = sel_sum;
`endif

   // ---------------- flow control ----------------------------------------
   logic s2_adv;
   logic in_ready;

   assign s2_adv   = !out_valid_q || bus.out_ready;
   assign in_ready = !s1_valid_q || s2_adv;

   always_comb begin : p_next
      s1_valid_d  = s1_valid_q;
      s1_sum0_d   = s1_sum0_q;
      s1_sum1_d   = s1_sum1_q;
      s1_c0_d     = s1_c0_q;
      s1_c1_d     = s1_c1_q;
      s1_mc0_d    = s1_mc0_q;
      s1_mc1_d    = s1_mc1_q;
      s1_ceff_d   = s1_ceff_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_cout_d  = out_cout_q;
      out_ovf_d   = out_ovf_q;

      // S1 data is loaded even for an idle cycle; s1_valid marks it empty.
      if (in_ready) begin
         s1_valid_d = bus.in_valid;
         s1_sum0_d  = seg_sum0;
         s1_sum1_d  = seg_sum1;
         s1_c0_d    = seg_c0;
         s1_c1_d    = seg_c1;
         s1_mc0_d   = seg_mc0[NSEG-1];
         s1_mc1_d   = seg_mc1[NSEG-1];
         s1_ceff_d  = c_eff;
      end

      // Result fields only change when a new beat moves in, so they stay
      // stable while stalled and after the last beat drains.
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_sum_d  = res_sum;
            out_cout_d = sel_cout;
            out_ovf_d  = sel_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sum0_q   <= '0;
         s1_sum1_q   <= '0;
         s1_c0_q     <= '0;
         s1_c1_q     <= '0;
         s1_mc0_q    <= 1'b0;
         s1_mc1_q    <= 1'b0;
         s1_ceff_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sum0_q   <= s1_sum0_d;
         s1_sum1_q   <= s1_sum1_d;
         s1_c0_q     <= s1_c0_d;
         s1_c1_q     <= s1_c1_d;
         s1_mc0_q    <= s1_mc0_d;
         s1_mc1_q    <= s1_mc1_d;
         s1_ceff_q   <= s1_ceff_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_cout_q  <= out_cout_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_cout  = out_cout_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_adder
// Directed bench for csa_pipe_adder: a WIDTH=16/SEG=4 instance and a
// WIDTH=8/SEG=8 (single segment) instance share clock and reset.
// Build option: CSA_SATURATION_EN selects the saturating expectations.
// ---------------------------------------------------------------------------
module tb_csa_pipe_adder;
   import csa_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   csa_pipe_adder_if #(.WIDTH(16)) bus16 ();
   csa_pipe_adder_if #(.WIDTH(8))  bus8  ();

   csa_pipe_adder #(.WIDTH(16), .SEG(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   csa_pipe_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

`ifdef CSA_SATURATION_EN
   localparam logic [15:0] EXP_POS_OVF16 = 16'h7FFF;
   localparam logic [15:0] EXP_NEG_OVF16 = 16'h8000;
   localparam logic [7:0]  EXP_POS_OVF8  = 8'h7F;
`else
   localparam logic [15:0] EXP_POS_OVF16 = 16'h8000;
   localparam logic [15:0] EXP_NEG_OVF16 = 16'h7FFF;
   localparam logic [7:0]  EXP_POS_OVF8  = 8'h80;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain wide addition, overflow from operand/result signs.
   function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
      logic [15:0] be;
      logic        ce;
      logic [16:0] s;
      logic        ovf;
      logic [15:0] r;
      be  = sub ? ~b : b;
      ce  = cin ^ sub;
      s   = {1'b0, a} + {1'b0, be} + {16'b0, ce};
      ovf = (a[15] == be[15]) && (s[15] != a[15]);
      r   = s[15:0];
`ifdef CSA_SATURATION_EN
      if (ovf) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {ovf, s[16], r};
   endfunction

   task automatic beat16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
      @(negedge clk);
      bus16.in_valid = 1'b1;
      bus16.in_a = a; bus16.in_b = b; bus16.in_cin = cin; bus16.in_sub = sub;
      bus16.out_ready = 1'b1;
      #1 check({tag, "_rdy"}, 32'(bus16.in_ready), 32'd1);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      #1 check({tag, "_lat1"}, 32'(bus16.out_valid), 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_vld"},  32'(bus16.out_valid), 32'd1);
      check({tag, "_sum"},  32'(bus16.out_sum),   32'(es));
      check({tag, "_cout"}, 32'(bus16.out_cout),  32'(ec));
      check({tag, "_ovf"},  32'(bus16.out_ovf),   32'(eo));
   endtask

   task automatic beat8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.in_a = a; bus8.in_b = b; bus8.in_cin = cin; bus8.in_sub = sub;
      bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      #1 check({tag, "_lat1"}, 32'(bus8.out_valid), 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_vld"},  32'(bus8.out_valid), 32'd1);
      check({tag, "_sum"},  32'(bus8.out_sum),   32'(es));
      check({tag, "_cout"}, 32'(bus8.out_cout),  32'(ec));
      check({tag, "_ovf"},  32'(bus8.out_ovf),   32'(eo));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] q[$];
      logic [17:0] exp_r;
      logic [17:0] cur_r;
      logic [17:0] held_r;
      bit          have_held;

      rst_n = 1'b0;
      bus16.in_valid = 1'b1; bus16.in_a = 16'h1234; bus16.in_b = 16'h1111;
      bus16.in_cin = 1'b0; bus16.in_sub = 1'b0; bus16.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.in_a = 8'h00; bus8.in_b = 8'h00;
      bus8.in_cin = 1'b0; bus8.in_sub = 1'b0; bus8.out_ready = 1'b1;

      // Reset held with a valid beat presented
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
      check("rst_out_sum",   32'(bus16.out_sum),   32'd0);
      check("rst_out_cout",  32'(bus16.out_cout),  32'd0);
      check("rst_out_ovf",   32'(bus16.out_ovf),   32'd0);
      check("rst_out8_valid",32'(bus8.out_valid),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus16.in_valid = 1'b0;
      #1;
      check("rst_in_ready",  32'(bus16.in_ready),  32'd1);
      check("rst_rel_valid", 32'(bus16.out_valid), 32'd0);

      // Directed 16-bit vectors
      beat16("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
      beat16("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, OP_ADD, EXP_POS_OVF16, 1'b0, 1'b1);
      beat16("sub_5_7",      16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b0, 1'b0);
      beat16("sub_5_7_cin",  16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFD, 1'b0, 1'b0);
      beat16("sub_8000_1",   16'h8000, 16'h0001, 1'b0, OP_SUB, EXP_NEG_OVF16, 1'b1, 1'b1);
      beat16("add_cin",      16'h1234, 16'h4321, 1'b1, OP_ADD, 16'h5556, 1'b0, 1'b0);
      beat16("add_segcarry", 16'h0F0F, 16'h00F1, 1'b0, OP_ADD, 16'h1000, 1'b0, 1'b0);
      beat16("add_ripple",   16'hFFFF, 16'h0000, 1'b1, OP_ADD, 16'h0000, 1'b1, 1'b0);
      beat16("sub_3_3",      16'h0003, 16'h0003, 1'b0, OP_SUB, 16'h0000, 1'b1, 1'b0);

      // Single-segment instance
      beat8("w8_add_7f_1",   8'h7F, 8'h01, 1'b0, OP_ADD, EXP_POS_OVF8, 1'b0, 1'b1);
      beat8("w8_add_ff_1",   8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0);
      beat8("w8_sub_10_20",  8'h10, 8'h20, 1'b0, OP_SUB, 8'hF0, 1'b0, 1'b0);

      // Backpressure: fill both stages, stall the third beat, then release
      @(negedge clk);
      bus16.out_ready = 1'b0;
      bus16.in_valid = 1'b1; bus16.in_a = 16'h0001; bus16.in_b = 16'h0001;
      bus16.in_cin = 1'b0; bus16.in_sub = OP_ADD;
      #1 check("bp_rdy1", 32'(bus16.in_ready), 32'd1);
      @(negedge clk);
      bus16.in_a = 16'h0010; bus16.in_b = 16'h0010;
      #1;
      check("bp_rdy2", 32'(bus16.in_ready), 32'd1);
      check("bp_vld0", 32'(bus16.out_valid), 32'd0);
      @(negedge clk);
      bus16.in_a = 16'h0100; bus16.in_b = 16'h0100;
      #1;
      check("bp_rdy3", 32'(bus16.in_ready), 32'd0);
      check("bp_vld1", 32'(bus16.out_valid), 32'd1);
      check("bp_sum1", 32'(bus16.out_sum), 32'h0002);
      @(negedge clk);
      #1;
      check("bp_hold_sum", 32'(bus16.out_sum), 32'h0002);
      check("bp_hold_rdy", 32'(bus16.in_ready), 32'd0);
      bus16.out_ready = 1'b1;
      #1 check("bp_rel_rdy", 32'(bus16.in_ready), 32'd1);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      #1;
      check("bp_vld2", 32'(bus16.out_valid), 32'd1);
      check("bp_sum2", 32'(bus16.out_sum), 32'h0020);
      @(negedge clk);
      #1;
      check("bp_vld3", 32'(bus16.out_valid), 32'd1);
      check("bp_sum3", 32'(bus16.out_sum), 32'h0200);
      @(negedge clk);
      #1 check("bp_empty", 32'(bus16.out_valid), 32'd0);

      // Random stream with random backpressure against the reference model
      have_held = 1'b0;
      held_r    = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         bus16.in_valid  = ($urandom_range(0, 3) != 0);
         bus16.in_a      = 16'($urandom);
         bus16.in_b      = 16'($urandom);
         bus16.in_cin    = 1'($urandom);
         bus16.in_sub    = 1'($urandom);
         bus16.out_ready = ($urandom_range(0, 9) < 7);
         #1;
         cur_r = {bus16.out_ovf, bus16.out_cout, bus16.out_sum};
         if (have_held) check("rand_hold", 32'(cur_r), 32'(held_r));
         have_held = bus16.out_valid && !bus16.out_ready;
         held_r    = cur_r;
         if (bus16.out_valid && bus16.out_ready) begin
            if (q.size() == 0) begin
               check("rand_spurious", 32'd1, 32'd0);
            end else begin
               exp_r = q.pop_front();
               check("rand_res", 32'(cur_r), 32'(exp_r));
            end
         end
         if (bus16.in_valid && bus16.in_ready)
            q.push_back(ref16(bus16.in_a, bus16.in_b, bus16.in_cin, bus16.in_sub));
      end
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         bus16.in_valid  = 1'b0;
         bus16.out_ready = 1'b1;
         #1;
         if (bus16.out_valid) begin
            cur_r = {bus16.out_ovf, bus16.out_cout, bus16.out_sum};
            if (q.size() == 0) begin
               check("rand_spurious", 32'd1, 32'd0);
            end else begin
               exp_r = q.pop_front();
               check("rand_res", 32'(cur_r), 32'(exp_r));
            end
         end
      end
      check("rand_drain", 32'(q.size()), 32'd0);

      // Reset with two beats in flight: nothing stale may appear afterwards
      @(negedge clk);
      bus16.out_ready = 1'b1;
      bus16.in_valid = 1'b1; bus16.in_a = 16'h0001; bus16.in_b = 16'h0002;
      bus16.in_cin = 1'b0; bus16.in_sub = OP_ADD;
      @(negedge clk);
      bus16.in_a = 16'h0003; bus16.in_b = 16'h0004;
      @(negedge clk);
      rst_n = 1'b0;
      bus16.in_valid = 1'b0;
      #1;
      check("mrst_pre_vld", 32'(bus16.out_valid), 32'd1);
      check("mrst_pre_sum", 32'(bus16.out_sum), 32'h0003);
      @(negedge clk);
      #1;
      check("mrst_vld", 32'(bus16.out_valid), 32'd0);
      check("mrst_sum", 32'(bus16.out_sum), 32'd0);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         #1 check("mrst_no_stale", 32'(bus16.out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
